dm_access_ctrl: RTL and testbench

Data-memory access controller between the core's load/store path (store unit output plus load request) and the single data-memory port, shared with a DMA requester. It arbitrates the two requesters and registers the winning request. It holds that request on the memory port until the memory signals ready, stalls the core while its access is pending, and returns read data to whichever requester issued the read.

---
 rtl/dm_ctrl_pkg.sv | 30 +++
 rtl/dm_access_ctrl_if.sv | 52 +++++
 rtl/dm_arb_pick.sv | 27 ++
 rtl/dm_access_ctrl.sv | 148 ++++++++++++++
 tb/tb_dm_access_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dm_ctrl_pkg
//  Purpose  : Shared types and helpers for the data-memory access controller.
//  Revision : 1.0 - initial release
// ============================================================================
package dm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY_CORE = 2'd1,
        BUSY_DMA  = 2'd2
    } dm_state_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } dm_req_t;

    localparam int c_default_starve_limit = 8;

    // Width needed to hold 0..limit inclusive.
    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : dm_access_ctrl_if
//  Purpose  : Core, DMA and data-memory port bundle for dm_access_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
interface dm_access_ctrl_if;
    logic        core_req_in;
    logic        core_wr_in;
    logic [31:0] core_addr_in;
    logic [31:0] core_wdata_in;
    logic [3:0]  core_mask_in;
    logic        core_stall_out;
    logic [31:0] core_rdata_out;
    logic        core_rvalid_out;

    logic        dma_req_in;
    logic        dma_wr_in;
    logic [31:0] dma_addr_in;
    logic [31:0] dma_wdata_in;
    logic [3:0]  dma_mask_in;
    logic        dma_ack_out;
    logic [31:0] dma_rdata_out;
    logic        dma_rvalid_out;

    logic        dm_req_out;
    logic        dm_wr_out;
    logic [31:0] dm_addr_out;
    logic [31:0] dm_data_out;
    logic [3:0]  dm_wr_mask_out;
    logic        dm_ready_in;
    logic [31:0] dm_rdata_in;

    modport slave (
        input  core_req_in, core_wr_in, core_addr_in, core_wdata_in, core_mask_in,
        output core_stall_out, core_rdata_out, core_rvalid_out,
        input  dma_req_in, dma_wr_in, dma_addr_in, dma_wdata_in, dma_mask_in,
        output dma_ack_out, dma_rdata_out, dma_rvalid_out,
        output dm_req_out, dm_wr_out, dm_addr_out, dm_data_out, dm_wr_mask_out,
        input  dm_ready_in, dm_rdata_in
    );

    modport master (
        output core_req_in, core_wr_in, core_addr_in, core_wdata_in, core_mask_in,
        input  core_stall_out, core_rdata_out, core_rvalid_out,
        output dma_req_in, dma_wr_in, dma_addr_in, dma_wdata_in, dma_mask_in,
        input  dma_ack_out, dma_rdata_out, dma_rvalid_out,
        input  dm_req_out, dm_wr_out, dm_addr_out, dm_data_out, dm_wr_mask_out,
        output dm_ready_in, dm_rdata_in
    );
endinterface
`default_nettype wire

// File: rtl/dm_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module   : dm_arb_pick
//  Purpose  : Core-priority winner selection with DMA anti-starvation override.
//  Revision : 1.0 - initial release
// ============================================================================
module dm_arb_pick
    import dm_ctrl_pkg::*;
#(
    parameter int STARVE_LIMIT = c_default_starve_limit
) (
    input  logic                                core_req,
    input  logic                                dma_req,
    input  logic [cnt_width(STARVE_LIMIT)-1:0]  starve_cnt,
    output logic                                grant_core,
    output logic                                grant_dma
);
    localparam int c_cnt_w = cnt_width(STARVE_LIMIT);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_LIMIT);

    logic w_dma_starved;

    assign w_dma_starved = dma_req & (starve_cnt == c_limit);
    assign grant_core    = core_req & ~w_dma_starved;
    assign grant_dma     = dma_req & ~grant_core;
endmodule
`default_nettype wire

// File: rtl/dm_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dm_access_ctrl
//  Purpose  : Arbitrates core and DMA onto the single data-memory port.
//  Revision : 1.0 - initial release
// ============================================================================
module dm_access_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter int DMA_STARVE_LIMIT = c_default_starve_limit
) (
    input  logic            clk_in,
    input  logic            rst_in,
    dm_access_ctrl_if.slave bus
);
    localparam int c_cnt_w = cnt_width(DMA_STARVE_LIMIT);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(DMA_STARVE_LIMIT);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    dm_state_t          r_state;
    dm_state_t          w_state_nxt;
    logic               w_arb_core;
    logic               w_arb_dma;
    logic               w_grant_core;
    logic               w_grant_dma;
    logic               w_done;
    dm_req_t            w_win;
    logic [c_cnt_w-1:0] r_starve_cnt;

    logic        r_dm_req;
    logic        r_dm_wr;
    logic [31:0] r_dm_addr;
    logic [31:0] r_dm_data;
    logic [3:0]  r_dm_mask;
    logic [31:0] r_core_rdata;
    logic        r_core_rvalid;
    logic [31:0] r_dma_rdata;
    logic        r_dma_rvalid;

    dm_arb_pick #(
        .STARVE_LIMIT (DMA_STARVE_LIMIT)
    ) u_arb (
        .core_req   (bus.core_req_in),
        .dma_req    (bus.dma_req_in),
        .starve_cnt (r_starve_cnt),
        .grant_core (w_arb_core),
        .grant_dma  (w_arb_dma)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_core = 1'b0;
        w_grant_dma  = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_core) begin
                    w_grant_core = 1'b1;
                    w_state_nxt  = BUSY_CORE;
                end else if (w_arb_dma) begin
                    w_grant_dma  = 1'b1;
                    w_state_nxt  = BUSY_DMA;
                end
            end
            BUSY_CORE, BUSY_DMA: begin
                if (bus.dm_ready_in) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        if (w_grant_core) begin
            w_win = '{wr: bus.core_wr_in, addr: bus.core_addr_in,
                      wdata: bus.core_wdata_in, mask: bus.core_mask_in};
        end else begin
            w_win = '{wr: bus.dma_wr_in, addr: bus.dma_addr_in,
                      wdata: bus.dma_wdata_in, mask: bus.dma_mask_in};
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_dm_req      <= 1'b0;
            r_dm_wr       <= 1'b0;
            r_dm_addr     <= '0;
            r_dm_data     <= '0;
            r_dm_mask     <= '0;
            r_core_rdata  <= '0;
            r_core_rvalid <= 1'b0;
            r_dma_rdata   <= '0;
            r_dma_rvalid  <= 1'b0;
            r_starve_cnt  <= '0;
        end else begin
            r_core_rvalid <= 1'b0;
            r_dma_rvalid  <= 1'b0;
            if (w_grant_core || w_grant_dma) begin
                r_dm_req  <= 1'b1;
                r_dm_wr   <= w_win.wr;
                r_dm_addr <= w_win.addr;
                r_dm_data <= w_win.wdata;
                r_dm_mask <= w_win.wr ? w_win.mask : 4'b0000;
            end else if (w_done) begin
                r_dm_req <= 1'b0;
                r_dm_wr  <= 1'b0;
                // Read data is steered back to whichever requester owns the access.
                if (!r_dm_wr) begin
                    if (r_state == BUSY_CORE) begin
                        r_core_rdata  <= bus.dm_rdata_in;
                        r_core_rvalid <= 1'b1;
                    end else begin
                        r_dma_rdata   <= bus.dm_rdata_in;
                        r_dma_rvalid  <= 1'b1;
                    end
                end
            end
            if (w_grant_dma) begin
                r_starve_cnt <= '0;
            end else if (w_grant_core && bus.dma_req_in && (r_starve_cnt != c_limit)) begin
                r_starve_cnt <= r_starve_cnt + c_one;
            end
        end
    end

    assign bus.core_stall_out  = bus.core_req_in & ~((r_state == BUSY_CORE) & bus.dm_ready_in);
    assign bus.dma_ack_out     = (r_state == BUSY_DMA) & bus.dm_ready_in;
    assign bus.dm_req_out      = r_dm_req;
    assign bus.dm_wr_out       = r_dm_wr;
    assign bus.dm_addr_out     = r_dm_addr;
    assign bus.dm_data_out     = r_dm_data;
    assign bus.dm_wr_mask_out  = r_dm_mask;
    assign bus.core_rdata_out  = r_core_rdata;
    assign bus.core_rvalid_out = r_core_rvalid;
    assign bus.dma_rdata_out   = r_dma_rdata;
    assign bus.dma_rvalid_out  = r_dma_rvalid;
endmodule
`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_access_ctrl
//  Purpose  : Directed and randomized checks of dm_access_ctrl against a model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dm_access_ctrl;
    import dm_ctrl_pkg::*;

    localparam int LIMIT = 2;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    dm_access_ctrl_if bus ();

    dm_access_ctrl #(
        .DMA_STARVE_LIMIT (LIMIT)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: who owns the port (0 none, 1 core, 2 dma) and what was granted.
    int          m_owner;
    logic        m_wr;
    logic [31:0] m_addr, m_data;
    logic [3:0]  m_mask;
    int          m_cnt;
    logic        m_crv, m_drv;
    logic [31:0] m_crd, m_drd;
    logic        m_last_stall, m_last_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_wr = 1'b0; m_addr = '0; m_data = '0; m_mask = '0;
        m_cnt = 0; m_crv = 1'b0; m_drv = 1'b0; m_crd = '0; m_drd = '0;
    endtask

    task automatic check_all();
        logic exp_stall, exp_ack;
        exp_stall = bus.core_req_in && !(m_owner == 1 && bus.dm_ready_in);
        exp_ack   = (m_owner == 2) && bus.dm_ready_in;
        chk("dm_req",      bus.dm_req_out, m_owner != 0);
        chk("dm_wr",       bus.dm_wr_out, (m_owner != 0) && m_wr);
        chk("dm_addr",     bus.dm_addr_out, m_addr);
        chk("dm_data",     bus.dm_data_out, m_data);
        chk("dm_mask",     bus.dm_wr_mask_out, m_mask);
        chk("core_stall",  bus.core_stall_out, exp_stall);
        chk("dma_ack",     bus.dma_ack_out, exp_ack);
        chk("core_rvalid", bus.core_rvalid_out, m_crv);
        chk("core_rdata",  bus.core_rdata_out, m_crd);
        chk("dma_rvalid",  bus.dma_rvalid_out, m_drv);
        chk("dma_rdata",   bus.dma_rdata_out, m_drd);
        chk("starve_cnt",  dut.r_starve_cnt, m_cnt);
        m_last_stall = exp_stall;
        m_last_ack   = exp_ack;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            m_crv = 1'b0;
            m_drv = 1'b0;
            if (m_owner != 0) begin
                if (bus.dm_ready_in) begin
                    if (!m_wr && m_owner == 1) begin m_crd = bus.dm_rdata_in; m_crv = 1'b1; end
                    if (!m_wr && m_owner == 2) begin m_drd = bus.dm_rdata_in; m_drv = 1'b1; end
                    m_owner = 0;
                end
            end else if (bus.core_req_in && !(bus.dma_req_in && m_cnt == LIMIT)) begin
                m_owner = 1;
                m_wr = bus.core_wr_in; m_addr = bus.core_addr_in; m_data = bus.core_wdata_in;
                m_mask = bus.core_wr_in ? bus.core_mask_in : 4'b0000;
                if (bus.dma_req_in && m_cnt < LIMIT) m_cnt = m_cnt + 1;
            end else if (bus.dma_req_in) begin
                m_owner = 2;
                m_wr = bus.dma_wr_in; m_addr = bus.dma_addr_in; m_data = bus.dma_wdata_in;
                m_mask = bus.dma_wr_in ? bus.dma_mask_in : 4'b0000;
                m_cnt = 0;
            end
        end
    endtask

    // Called one time unit after inputs settle; advances to the next negedge.
    task automatic step();
        check_all();
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic set_core(input logic req, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] mask);
        bus.core_req_in = req; bus.core_wr_in = wr; bus.core_addr_in = addr;
        bus.core_wdata_in = wdata; bus.core_mask_in = mask;
    endtask

    task automatic set_dma(input logic req, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask);
        bus.dma_req_in = req; bus.dma_wr_in = wr; bus.dma_addr_in = addr;
        bus.dma_wdata_in = wdata; bus.dma_mask_in = mask;
    endtask

    logic [31:0] exp_addr [6];
    int          hold_cnt;

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        m_last_stall = 1'b0;
        m_last_ack   = 1'b0;
        rst = 1'b1;
        set_core(1'b0, 1'b0, '0, '0, '0);
        set_dma(1'b0, 1'b0, '0, '0, '0);
        bus.dm_ready_in = 1'b0;
        bus.dm_rdata_in = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", dut.r_state, IDLE);
        rst = 1'b0;
        #1;
        step();

        // Core store, zero wait
        set_core(1'b1, 1'b1, 32'h104, 32'h00AB_0000, 4'b0100);
        bus.dm_ready_in = 1'b1;
        #1;
        chk("t1_stall_c0", bus.core_stall_out, 1'b1);
        step();
        chk("t1_dm_req_c1", bus.dm_req_out, 1'b1);
        chk("t1_addr_c1", bus.dm_addr_out, 32'h104);
        chk("t1_mask_c1", bus.dm_wr_mask_out, 4'b0100);
        chk("t1_stall_c1", bus.core_stall_out, 1'b0);
        step();
        set_core(1'b0, 1'b0, '0, '0, '0);
        bus.dm_ready_in = 1'b0;
        #1;
        chk("t1_no_rvalid", bus.core_rvalid_out, 1'b0);
        step();

        // DMA load, three wait states
        set_dma(1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("t2_ack_wait", bus.dma_ack_out, 1'b0);
            chk("t2_mask_zero", bus.dm_wr_mask_out, 4'b0000);
            step();
        end
        bus.dm_ready_in = 1'b1;
        bus.dm_rdata_in = 32'hDEAD_BEEF;
        #1;
        chk("t2_ack_4th", bus.dma_ack_out, 1'b1);
        chk("t2_mask_zero_end", bus.dm_wr_mask_out, 4'b0000);
        step();
        set_dma(1'b0, 1'b0, '0, '0, '0);
        bus.dm_ready_in = 1'b0;
        #1;
        chk("t2_rvalid", bus.dma_rvalid_out, 1'b1);
        chk("t2_rdata", bus.dma_rdata_out, 32'hDEAD_BEEF);
        step();

        // Starvation with limit 2
        exp_addr[0] = 32'h1000; exp_addr[1] = 32'h1000; exp_addr[2] = 32'h2000;
        exp_addr[3] = 32'h1000; exp_addr[4] = 32'h1000; exp_addr[5] = 32'h2000;
        set_core(1'b1, 1'b1, 32'h1000, 32'h11, 4'hF);
        set_dma(1'b1, 1'b1, 32'h2000, 32'h22, 4'hF);
        bus.dm_ready_in = 1'b1;
        #1;
        step();
        for (int i = 0; i < 6; i++) begin
            chk("t3_grant_order", bus.dm_addr_out, exp_addr[i]);
            if (exp_addr[i] == 32'h2000) chk("t3_starve_clr", dut.r_starve_cnt, 0);
            step();
            if (i < 5) step();
        end
        set_core(1'b0, 1'b0, '0, '0, '0);
        set_dma(1'b0, 1'b0, '0, '0, '0);
        bus.dm_ready_in = 1'b0;
        #1;
        step();

        // Input change after grant
        set_core(1'b1, 1'b0, 32'h104, 32'h0, 4'hF);
        #1;
        step();
        bus.core_addr_in = 32'h200;
        #1;
        chk("t4_addr_hold1", bus.dm_addr_out, 32'h104);
        step();
        chk("t4_addr_hold2", bus.dm_addr_out, 32'h104);
        bus.dm_ready_in = 1'b1;
        bus.dm_rdata_in = 32'h1234_5678;
        #1;
        step();
        set_core(1'b0, 1'b0, '0, '0, '0);
        bus.dm_ready_in = 1'b0;
        #1;
        chk("t4_rvalid", bus.core_rvalid_out, 1'b1);
        chk("t4_rdata", bus.core_rdata_out, 32'h1234_5678);
        step();

        // Reset mid-access
        set_dma(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        #1;
        step();
        rst = 1'b1;
        set_dma(1'b0, 1'b0, '0, '0, '0);
        #1;
        step();
        rst = 1'b0;
        #1;
        chk("t5_state", dut.r_state, IDLE);
        chk("t5_dm_req", bus.dm_req_out, 1'b0);
        chk("t5_dm_addr", bus.dm_addr_out, 32'h0);
        chk("t5_dma_rdata", bus.dma_rdata_out, 32'h0);
        chk("t5_core_rdata", bus.core_rdata_out, 32'h0);
        step();
        chk("t5_no_rvalid", bus.dma_rvalid_out, 1'b0);
        set_dma(1'b1, 1'b1, 32'h44, 32'h55, 4'b0011);
        bus.dm_ready_in = 1'b1;
        #1;
        step();
        chk("t5_after_addr", bus.dm_addr_out, 32'h44);
        chk("t5_after_ack", bus.dma_ack_out, 1'b1);
        step();
        set_dma(1'b0, 1'b0, '0, '0, '0);
        bus.dm_ready_in = 1'b0;
        #1;
        step();

        // Spurious ready with a non-zero starve count
        set_core(1'b1, 1'b1, 32'h80, 32'h99, 4'hF);
        set_dma(1'b1, 1'b0, 32'h90, 32'h0, 4'h0);
        bus.dm_ready_in = 1'b1;
        #1;
        step();
        bus.dma_req_in = 1'b0;
        #1;
        step();
        set_core(1'b0, 1'b0, '0, '0, '0);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("t6_starve_kept", dut.r_starve_cnt, 1);
            chk("t6_state", dut.r_state, IDLE);
            chk("t6_no_ack", bus.dma_ack_out, 1'b0);
            step();
        end

        // Randomized traffic respecting the hold-until-stall/ack protocol
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!(bus.core_req_in && m_last_stall))
                set_core($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom,
                         $urandom, 4'($urandom_range(0, 15)));
            if (!(bus.dma_req_in && !m_last_ack))
                set_dma($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom,
                        $urandom, 4'($urandom_range(0, 15)));
            bus.dm_ready_in = $urandom_range(0, 4) < 3;
            bus.dm_rdata_in = $urandom;
            rst = ($urandom_range(0, 59) == 0);
            hold_cnt = cyc;
            #1;
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
